fdiv_seq: RTL and testbench
===========================

# fdiv_seq

Iterative IEEE-754 single-precision divider, d = s / t, the sequential counterpart to the FPU's combinational multiplier. It accepts operands over a valid/ready handshake and computes the quotient mantissa with radix-2 restoring division, one bit per cycle. It rounds to nearest-even and holds the result until it is consumed. It sits in the FPU beside the multiplier and is used by the core's FDIV instruction, which stalls on `in_ready`/`out_valid`.

## Interface
- No parameters. Format is fixed at binary32.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands present on `s`, `t`.
- `in_ready` output 1: high only in IDLE. Accept occurs when `in_valid && in_ready`.
- `s` input 32: dividend.
- `t` input 32: divisor.
- `out_valid` output 1: result valid; held until accepted.
- `out_ready` input 1: consumer takes the result when `out_valid && out_ready`.
- `d` output 32: quotient.
- `overflow` output 1: finite quotient rounded above the max exponent.
- `underflow` output 1: nonzero finite quotient flushed to zero.
- `divzero` output 1: finite nonzero / zero.

## Operation
- States: IDLE, UNPACK, DIV, ROUND, DONE.
- IDLE: on accept, register `s`, `t` and go to UNPACK.
- UNPACK, classification:
  - Exponent 0 means zero; denormals are flushed to zero.
  - Exponent 255 with mantissa 0 is inf; exponent 255 with mantissa ≠ 0 is NaN.
  - Sign = `s[31]^t[31]`.
- UNPACK, special results go directly to DONE:
  - Any NaN, 0/0, or inf/inf: `d=32'h7FC00000`.
  - Finite nonzero / 0: signed inf, `divzero=1`.
  - inf / (finite or 0): signed inf.
  - 0 / nonzero finite, or finite / inf: signed zero.
- UNPACK, normal path:
  - Signed 10-bit exponent `e = es - et + 127`.
  - Remainder `r = {2'b0, 1, ms}` (26 bit).
  - Divisor `b = {1, mt}`.
  - Quotient `q = 0` (26 bit). Counter = 25. Go to DIV.
- DIV (26 cycles, counter 25 down to 0):
  - If `r >= b`: `q[counter]=1`, `r = r - b`; else `q[counter]=0`.
  - Then `r = r << 1`.
  - At counter 0, go to ROUND.
  - `q` is the quotient with weight 2^0 at bit 25; it is in (0.5, 2).
- ROUND:
  - If `q[25]=1`: mantissa `q[25:2]`, guard `q[1]`, sticky `q[0] | (r≠0)`.
  - Else: mantissa `q[24:1]`, guard `q[0]`, sticky `r≠0`, and `e = e - 1`.
  - Increment the mantissa when `guard && (sticky || lsb)`.
  - On carry-out to 2.0, mantissa becomes 1.0 and `e + 1`.
  - Final `e >= 255`: signed inf, `overflow=1`.
  - Final `e <= 0`: signed zero, `underflow=1`.
  - Otherwise `{sign, e[7:0], mant[22:0]}`.
  - Go to DONE.
- DONE:
  - `out_valid=1`. `d` and the flags are stable.
  - On `out_ready`, go to IDLE. Outputs keep their value but are no longer valid.
- Flags are mutually exclusive and are updated only when DONE is entered.

## Timing
- Reset (async, while `rstn=0`):
  - State is IDLE, so `in_ready=1`.
  - `out_valid=0`, `d=0`, `overflow=underflow=divzero=0`.
  - Counter and datapath registers are cleared.
- Reset mid-operation aborts the operation with no result; `in_ready=1` follows immediately.
- Latency, counting the accept edge as edge 0 and the first cycle after it as cycle 1:
  - Special cases: `out_valid` is high from cycle 2.
  - Normal: UNPACK in cycle 1, DIV in cycles 2–27, ROUND in cycle 28, `out_valid` high from cycle 29.
- Back-to-back:
  - `in_ready` is 0 from cycle 1 through the cycle the output is accepted.
  - `in_ready` rises the cycle after the `out_valid && out_ready` edge.
  - Minimum normal issue interval is 30 cycles.
- Backpressure: `out_ready=0` holds DONE indefinitely with `d` unchanged.
- `in_valid` outside IDLE is ignored; operands are not re-sampled.

## Test plan
- 6.0/2.0 (`40C00000`/`40000000`) → `d=40400000`, no flags, `out_valid` exactly 29 cycles after accept.
- 1.0/3.0 (`3F800000`/`40400000`) → `d=3EAAAAAB` (round-up path). 1.5/1.0 → `3FC00000` (exact, sticky 0).
- 1.0/0 (`3F800000`/`00000000`) → `d=7F800000`, `divzero=1`, latency 2.
- 0/0 → `7FC00000`. inf/inf → `7FC00000`. NaN/1.0 → `7FC00000`. -1.0/inf → `80000000`.
- 2^127/0.25 (`7F000000`/`3E800000`) → `d=7F800000`, `overflow=1`.
- 2^-126/2.0 (`00800000`/`40000000`) → `d=00000000`, `underflow=1`.
- Hold `out_ready=0` for 10 cycles: `d` stays stable and `in_ready=0` throughout.
- Drop `rstn` in cycle 15 of DIV: all outputs return to reset values and the next accept computes correctly.

Source files
------------

// File: rtl/fdiv_seq.sv
// Iterative IEEE-754 binary32 divider: radix-2 restoring division, one quotient bit per cycle,
// round-to-nearest-even, denormals flushed to zero, valid/ready handshake on both sides.
module fdiv_seq (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] s,
    input  logic [31:0] t,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] d,
    output logic        overflow,
    output logic        underflow,
    output logic        divzero
);

    typedef enum logic [2:0] {IDLE, UNPACK, DIV, ROUND, DONE} state_t;

    state_t             r_state;
    logic [31:0]        r_s;
    logic [31:0]        r_t;
    logic               r_sign;
    logic signed [9:0]  r_exp;
    logic [25:0]        r_rem;
    logic [23:0]        r_div;
    logic [25:0]        r_quo;
    logic [4:0]         r_cnt;
    logic [31:0]        r_d;
    logic               r_ovf;
    logic               r_unf;
    logic               r_dz;

    logic [7:0]         w_sExp;
    logic [7:0]         w_tExp;
    logic               w_sZero;
    logic               w_tZero;
    logic               w_sInf;
    logic               w_tInf;
    logic               w_sNan;
    logic               w_tNan;
    logic               w_sign;

    logic               w_ge;
    logic [25:0]        w_remSel;

    logic [22:0]        w_frac;
    logic               w_guard;
    logic               w_sticky;
    logic               w_inc;
    logic [23:0]        w_fracSum;
    logic signed [9:0]  w_expAdj;
    logic signed [9:0]  w_expFinal;

    assign w_sExp  = r_s[30:23];
    assign w_tExp  = r_t[30:23];
    assign w_sZero = (w_sExp == 8'd0);
    assign w_tZero = (w_tExp == 8'd0);
    assign w_sInf  = (w_sExp == 8'hFF) && (r_s[22:0] == 23'd0);
    assign w_tInf  = (w_tExp == 8'hFF) && (r_t[22:0] == 23'd0);
    assign w_sNan  = (w_sExp == 8'hFF) && (r_s[22:0] != 23'd0);
    assign w_tNan  = (w_tExp == 8'hFF) && (r_t[22:0] != 23'd0);
    assign w_sign  = r_s[31] ^ r_t[31];

    // Restoring step: the remainder stays below twice the divisor, so 26 bits never overflow.
    assign w_ge     = (r_rem >= {2'b00, r_div});
    assign w_remSel = w_ge ? (r_rem - {2'b00, r_div}) : r_rem;

    // Normalise q from (0.5, 2) to [1, 2); the hidden bit is always set, so only the fraction is rounded.
    assign w_frac     = r_quo[25] ? r_quo[24:2] : r_quo[23:1];
    assign w_guard    = r_quo[25] ? r_quo[1] : r_quo[0];
    assign w_sticky   = r_quo[25] ? (r_quo[0] | (r_rem != 26'd0)) : (r_rem != 26'd0);
    assign w_inc      = w_guard && (w_sticky || w_frac[0]);
    assign w_fracSum  = {1'b0, w_frac} + {23'd0, w_inc};
    assign w_expAdj   = r_quo[25] ? r_exp : (r_exp - 10'sd1);
    assign w_expFinal = w_fracSum[23] ? (w_expAdj + 10'sd1) : w_expAdj;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign d         = r_d;
    assign overflow  = r_ovf;
    assign underflow = r_unf;
    assign divzero   = r_dz;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_s     <= 32'd0;
            r_t     <= 32'd0;
            r_sign  <= 1'b0;
            r_exp   <= 10'sd0;
            r_rem   <= 26'd0;
            r_div   <= 24'd0;
            r_quo   <= 26'd0;
            r_cnt   <= 5'd0;
            r_d     <= 32'd0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_s     <= s;
                        r_t     <= t;
                        r_state <= UNPACK;
                    end
                end
                UNPACK: begin
                    r_sign <= w_sign;
                    if (w_sNan || w_tNan || (w_sZero && w_tZero) || (w_sInf && w_tInf)) begin
                        r_d     <= 32'h7FC00000;
                        r_ovf   <= 1'b0;
                        r_unf   <= 1'b0;
                        r_dz    <= 1'b0;
                        r_state <= DONE;
                    end else if (w_tZero && !w_sInf && !w_sZero) begin
                        r_d     <= {w_sign, 8'hFF, 23'd0};
                        r_ovf   <= 1'b0;
                        r_unf   <= 1'b0;
                        r_dz    <= 1'b1;
                        r_state <= DONE;
                    end else if (w_sInf) begin
                        r_d     <= {w_sign, 8'hFF, 23'd0};
                        r_ovf   <= 1'b0;
                        r_unf   <= 1'b0;
                        r_dz    <= 1'b0;
                        r_state <= DONE;
                    end else if (w_sZero || w_tInf) begin
                        r_d     <= {w_sign, 31'd0};
                        r_ovf   <= 1'b0;
                        r_unf   <= 1'b0;
                        r_dz    <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_exp   <= $signed({2'b00, w_sExp}) - $signed({2'b00, w_tExp}) + 10'sd127;
                        r_rem   <= {2'b00, 1'b1, r_s[22:0]};
                        r_div   <= {1'b1, r_t[22:0]};
                        r_quo   <= 26'd0;
                        r_cnt   <= 5'd25;
                        r_state <= DIV;
                    end
                end
                DIV: begin
                    r_quo[r_cnt] <= w_ge;
                    r_rem        <= {w_remSel[24:0], 1'b0};
                    r_cnt        <= r_cnt - 5'd1;
                    if (r_cnt == 5'd0) begin
                        r_state <= ROUND;
                    end
                end
                ROUND: begin
                    r_dz <= 1'b0;
                    if (w_expFinal >= 10'sd255) begin
                        r_d   <= {r_sign, 8'hFF, 23'd0};
                        r_ovf <= 1'b1;
                        r_unf <= 1'b0;
                    end else if (w_expFinal <= 10'sd0) begin
                        r_d   <= {r_sign, 31'd0};
                        r_ovf <= 1'b0;
                        r_unf <= 1'b1;
                    end else begin
                        r_d   <= {r_sign, w_expFinal[7:0], w_fracSum[22:0]};
                        r_ovf <= 1'b0;
                        r_unf <= 1'b0;
                    end
                    r_state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed-vector bench for fdiv_seq: hand-computed quotients, flags, latency, backpressure and reset abort.
module tb_fdiv_seq;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] s;
    logic [31:0] t;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] d;
    logic        overflow;
    logic        underflow;
    logic        divzero;

    int assertCount;
    int failCount;

    fdiv_seq dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .t         (t),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .overflow  (overflow),
        .underflow (underflow),
        .divzero   (divzero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Present operands at a falling edge and leave the bench in cycle 1 after the accept edge.
    task automatic applyStimulus(input logic [31:0] sv, input logic [31:0] tv);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) checkOutput("in_ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        s        = sv;
        t        = tv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic runDiv(input string tag, input logic [31:0] sv, input logic [31:0] tv,
                          input logic [31:0] expD, input logic [2:0] expFlags,
                          input int expLat, input int holdCycles);
        int lat;
        applyStimulus(sv, tv);
        checkOutput({tag, ":busy"}, {31'd0, in_ready}, 32'd0);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, ":lat"}, lat, expLat);
        checkOutput({tag, ":d"}, d, expD);
        checkOutput({tag, ":flags"}, {29'd0, overflow, underflow, divzero}, {29'd0, expFlags});
        for (int i = 0; i < holdCycles; i++) begin
            in_valid = 1'b1;
            s        = 32'h40A00000;
            t        = 32'h3F800000;
            @(posedge clk);
            #1;
            checkOutput({tag, ":hold_d"}, d, expD);
            checkOutput({tag, ":hold_hs"}, {30'd0, in_ready, out_valid}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, ":release"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rstn        = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        s           = 32'd0;
        t           = 32'd0;
        #12;
        checkOutput("reset_hs", {30'd0, in_ready, out_valid}, 32'd2);
        checkOutput("reset_d", d, 32'd0);
        checkOutput("reset_flags", {29'd0, overflow, underflow, divzero}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        runDiv("6/2",        32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 29, 0);
        runDiv("1/3",        32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000, 29, 0);
        runDiv("1.5/1",      32'h3FC00000, 32'h3F800000, 32'h3FC00000, 3'b000, 29, 0);
        runDiv("1/1.5",      32'h3F800000, 32'h3FC00000, 32'h3F2AAAAB, 3'b000, 29, 0);
        runDiv("-6/2",       32'hC0C00000, 32'h40000000, 32'hC0400000, 3'b000, 29, 0);
        runDiv("1/-3",       32'h3F800000, 32'hC0400000, 32'hBEAAAAAB, 3'b000, 29, 0);
        runDiv("1/0",        32'h3F800000, 32'h00000000, 32'h7F800000, 3'b001, 2, 0);
        runDiv("-1/0",       32'hBF800000, 32'h00000000, 32'hFF800000, 3'b001, 2, 0);
        runDiv("0/0",        32'h00000000, 32'h00000000, 32'h7FC00000, 3'b000, 2, 0);
        runDiv("inf/inf",    32'h7F800000, 32'h7F800000, 32'h7FC00000, 3'b000, 2, 0);
        runDiv("nan/1",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b000, 2, 0);
        runDiv("-1/inf",     32'hBF800000, 32'h7F800000, 32'h80000000, 3'b000, 2, 0);
        runDiv("-inf/2",     32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, 2, 0);
        runDiv("inf/0",      32'h7F800000, 32'h00000000, 32'h7F800000, 3'b000, 2, 0);
        runDiv("0/-1",       32'h00000000, 32'hBF800000, 32'h80000000, 3'b000, 2, 0);
        runDiv("denorm/1",   32'h00000001, 32'h3F800000, 32'h00000000, 3'b000, 2, 0);
        runDiv("ovf",        32'h7F000000, 32'h3E800000, 32'h7F800000, 3'b100, 29, 0);
        runDiv("unf",        32'h00800000, 32'h40000000, 32'h00000000, 3'b010, 29, 0);
        runDiv("backpress",  32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 29, 10);

        // Abort a division in its 15th DIV cycle, then confirm a clean restart.
        applyStimulus(32'h40C00000, 32'h40000000);
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        rstn = 1'b0;
        #1;
        checkOutput("abort_hs", {30'd0, in_ready, out_valid}, 32'd2);
        checkOutput("abort_d", d, 32'd0);
        checkOutput("abort_flags", {29'd0, overflow, underflow, divzero}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        runDiv("after_abort", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000, 29, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
